data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//   Multi-cycle data-memory target serving load/store requests from the pipeline's MEM stage.
//   Accepts one request per valid/ready handshake and models a fixed wait-state latency.
//   Returns the result on a valid/ready response channel.
//   Replaces the zero-latency DataMemory when the CPU is built with stall-on-memory support.
// PARAMETERS
//   N_DATA       512  number of 32-bit words stored
//   ADDR_W       9    word-index width, clog2(N_DATA)
//   WAIT_CYCLES  2    wait states between accept and response, 0..15
// PORTS
//   CLK        in   1   clock, all state updates on posedge
//   RST_N      in   1   asynchronous active-low reset
//   ReqValid   in   1   request present
//   ReqReady   out  1   responder can accept a request
//   ReqWrite   in   1   1 = store, 0 = load
//   ReqAddr    in   32  byte address (ALUOutM)
//   ReqWData   in   32  store data (WriteDataM)
//   RspValid   out  1   response present
//   RspReady   in   1   requester takes the response
//   RspRData   out  32  load data; 0 for stores
//   RspErr     out  1   access error flag
// BEHAVIOUR
//   Reset and clock
//     - One clock: CLK. Reset: RST_N, asynchronous assert, active-low.
//     - While RST_N=0: state=IDLE, ReqReady=1, RspValid=0, RspRData=0, RspErr=0, wait counter=0.
//     - Memory array is not cleared by reset. Contents persist; simulation init is 0.
//   FSM states: IDLE, WAIT, RESP. At most one request is outstanding.
//   IDLE
//     - ReqReady=1.
//     - On ReqValid=1 at posedge: latch ReqWrite/ReqAddr/ReqWData; ReqReady drops next cycle.
//     - If WAIT_CYCLES>0: go to WAIT, counter=WAIT_CYCLES-1. If WAIT_CYCLES=0: go to RESP.
//   WAIT
//     - ReqReady=0. Counter decrements each cycle.
//     - When the counter is 0 at posedge: perform the access and go to RESP.
//   Access edge (entry to RESP)
//     - Store: mem[idx] <= data; RspRData <= 0.
//     - Load: RspRData <= mem[idx].
//     - idx = latched addr[ADDR_W+1:2].
//   RESP
//     - RspValid=1. RspRData and RspErr are held stable until RspReady=1.
//     - On RspReady=1: go to IDLE; RspValid=0 and ReqReady=1 next cycle.
//   Latency: accept-edge to RspValid high = WAIT_CYCLES+1 cycles. Throughput: one request per WAIT_CYCLES+2 cycles minimum.
//   Out of range (addr >= 4*N_DATA): store dropped; load returns 0; RspErr=1.
//   ReqValid while ReqReady=0 is ignored. The requester must hold the request until accepted.
//   Reset mid-operation: FSM returns to IDLE immediately.
//     - A store not yet at its access edge is discarded.
//     - A store already committed stays committed.
//   Load from an address stored by the immediately preceding request returns the new data, since accesses are strictly ordered.
// CONFIGURATION
//   DMEM_MISALIGN_CHECK_EN
//     - Defined: ReqAddr[1:0]!=0 sets RspErr=1; store suppressed; RspRData=0.
//     - Undefined: ReqAddr[1:0] ignored (word-aligned access); RspErr set only for out-of-range.
//   The RspErr port exists in both builds.
// TESTING
//   1. Reset, then store 0xDEADBEEF @0x10, then load @0x10 (WAIT_CYCLES=2) -> store RspValid 3 cycles after accept; load RspRData=0xDEADBEEF, RspErr=0.
//   2. Load response with RspReady=0 for 4 cycles -> RspValid and RspRData held 4 cycles; ReqReady=0 throughout; IDLE one cycle after RspReady=1.
//   3. WAIT_CYCLES=0, back-to-back loads @0x0/@0x4 with ReqValid held high -> each response 1 cycle after accept; accepts 2 cycles apart.
//   4. Store @0x800 (N_DATA=512) -> RspErr=1; then load @0x0 -> mem[0] unchanged.
//   5. Store 0x12345678 @0x20, assert RST_N=0 during WAIT -> outputs at reset values; load @0x20 after reset returns the prior value.
//   6. Store @0x22: with DMEM_MISALIGN_CHECK_EN -> RspErr=1 and mem[8] unchanged; without it -> mem[8] written, RspErr=0.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
// master = requester (pipeline), slave = responder.
interface data_mem_responder_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RspValid;
    logic        RspReady;
    logic [31:0] RspRData;
    logic        RspErr;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, RspReady,
        input  ReqReady, RspValid, RspRData, RspErr
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, RspReady,
        output ReqReady, RspValid, RspRData, RspErr
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory with fixed wait states and valid/ready channels.
// Optional DMEM_MISALIGN_CHECK_EN flags ReqAddr[1:0]!=0 as an access error.
module data_mem_responder #(
    parameter int N_DATA      = 512,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input logic                  CLK,
    input logic                  RST_N,
    data_mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [31:0] LIMIT = 32'(4 * N_DATA);

    state_t      state, stateNext;
    logic [3:0]  cnt, cntNext;
    logic        doAccess;
    logic        wrL;
    logic [31:0] addrL, dataL;
    logic [31:0] rdataQ;
    logic        errQ;

    logic              accWrite;
    logic [31:0]       accAddr, accData;
    logic              accErr;
    logic [ADDR_W-1:0] accIdx;

    logic [31:0] mem [N_DATA];

    // With zero wait states the access happens on the accept edge itself,
    // so the live request is used instead of the latched copy.
    always_comb begin
        accWrite = (state == IDLE) ? bus.ReqWrite : wrL;
        accAddr  = (state == IDLE) ? bus.ReqAddr  : addrL;
        accData  = (state == IDLE) ? bus.ReqWData : dataL;
        accIdx   = accAddr[ADDR_W+1:2];
        accErr   = (accAddr >= LIMIT);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (accAddr[1:0] != 2'b00) accErr = 1'b1;
`endif
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        doAccess  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.ReqValid) begin
                    if (WAIT_CYCLES == 0) begin
                        stateNext = RESP;
                        doAccess  = 1'b1;
                    end else begin
                        stateNext = WAIT;
                        cntNext   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    stateNext = RESP;
                    doAccess  = 1'b1;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.RspReady) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            wrL    <= 1'b0;
            addrL  <= 32'd0;
            dataL  <= 32'd0;
            rdataQ <= 32'd0;
            errQ   <= 1'b0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
            if (state == IDLE && bus.ReqValid) begin
                wrL   <= bus.ReqWrite;
                addrL <= bus.ReqAddr;
                dataL <= bus.ReqWData;
            end
            if (doAccess) begin
                rdataQ <= (accWrite || accErr) ? 32'd0 : mem[accIdx];
                errQ   <= accErr;
            end
        end
    end

    // Array is never reset; contents survive RST_N.
    always_ff @(posedge CLK) begin
        if (RST_N && doAccess && accWrite && !accErr) mem[accIdx] <= accData;
    end

    assign bus.ReqReady = (state == IDLE);
    assign bus.RspValid = (state == RESP);
    assign bus.RspRData = rdataQ;
    assign bus.RspErr   = errQ;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed plus randomized bench for data_mem_responder.
// Two instances: WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_data_mem_responder;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    data_mem_responder_if busA ();
    data_mem_responder_if busB ();

    data_mem_responder #(.N_DATA(512), .ADDR_W(9), .WAIT_CYCLES(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(busA)
    );
    data_mem_responder #(.N_DATA(512), .ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .bus(busB)
    );

    virtual data_mem_responder_if vif;
    int sel;
    int curW;
    int nCmp = 0;
    int nBad = 0;
    logic [31:0] refMem [2][512];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: word memory of 512 entries, byte addresses >= 2048 are errors.
    function automatic void refAccess(input int s, input bit w, input logic [31:0] a,
                                      input logic [31:0] d, output logic [31:0] rd,
                                      output logic err);
        int idx;
        err = (a >= 32'd2048);
`ifdef DMEM_MISALIGN_CHECK_EN
        if (a % 4 != 0) err = 1'b1;
`endif
        rd = 32'd0;
        if (!err) begin
            idx = int'(a / 4);
            if (w) refMem[s][idx] = d;
            else rd = refMem[s][idx];
        end
    endfunction

    task automatic doReq(input bit w, input logic [31:0] a, input logic [31:0] d,
                         input int hold, output logic [31:0] rd, output logic er);
        logic [31:0] expRd;
        logic expErr;
        int n;
        refAccess(sel, w, a, d, expRd, expErr);
        vif.ReqValid = 1'b1;
        vif.ReqWrite = w;
        vif.ReqAddr  = a;
        vif.ReqWData = d;
        vif.RspReady = 1'b0;
        n = 0;
        while (!vif.ReqReady && n < 100) begin
            @(posedge CLK); #1; n++;
        end
        chk("accept-ready", 32'(vif.ReqReady), 32'd1);
        @(posedge CLK); #1;
        vif.ReqValid = 1'b0;
        vif.ReqAddr  = $urandom;
        vif.ReqWData = $urandom;
        n = 1;
        while (!vif.RspValid && n < 50) begin
            @(posedge CLK); #1; n++;
        end
        chk("latency", 32'(n), 32'(curW + 1));
        chk("rdata", vif.RspRData, expRd);
        chk("err", 32'(vif.RspErr), 32'(expErr));
        rd = vif.RspRData;
        er = vif.RspErr;
        for (int k = 0; k < hold; k++) begin
            @(posedge CLK); #1;
            chk("hold-valid", 32'(vif.RspValid), 32'd1);
            chk("hold-rdata", vif.RspRData, expRd);
            chk("hold-err", 32'(vif.RspErr), 32'(expErr));
            chk("hold-busy", 32'(vif.ReqReady), 32'd0);
        end
        vif.RspReady = 1'b1;
        @(posedge CLK); #1;
        vif.RspReady = 1'b0;
        chk("rsp-drop", 32'(vif.RspValid), 32'd0);
        chk("idle-ready", 32'(vif.ReqReady), 32'd1);
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "-ready"}, 32'(busA.ReqReady), 32'd1);
        chk({tag, "-valid"}, 32'(busA.RspValid), 32'd0);
        chk({tag, "-rdata"}, busA.RspRData, 32'd0);
        chk({tag, "-err"}, 32'(busA.RspErr), 32'd0);
    endtask

    function automatic logic [31:0] randAddr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'h800 + 32'($urandom_range(0, 4095));
        if (r == 1) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        return 32'($urandom_range(0, 15) * 4);
    endfunction

    initial begin
        logic [31:0] rd;
        logic er;
        logic [31:0] prior;
        busA.ReqValid = 0; busA.ReqWrite = 0; busA.ReqAddr = 0;
        busA.ReqWData = 0; busA.RspReady = 0;
        busB.ReqValid = 0; busB.ReqWrite = 0; busB.ReqAddr = 0;
        busB.ReqWData = 0; busB.RspReady = 0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 512; i++) refMem[s][i] = 32'd0;

        repeat (3) @(posedge CLK);
        #1;
        checkReset("reset");
        RST_N = 1'b1;
        @(posedge CLK); #1;

        sel = 0; curW = 2; vif = busA;
        for (int i = 0; i < 16; i++) doReq(1'b1, 32'(i * 4), $urandom, 0, rd, er);

        doReq(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er);
        chk("t1-store-rdata", rd, 32'd0);
        doReq(1'b0, 32'h10, 32'd0, 0, rd, er);
        chk("t1-load", rd, 32'hDEADBEEF);
        chk("t1-err", 32'(er), 32'd0);

        doReq(1'b0, 32'h10, 32'd0, 4, rd, er);

        doReq(1'b1, 32'h800, 32'hCAFEF00D, 1, rd, er);
        chk("t4-oor-err", 32'(er), 32'd1);
        prior = refMem[0][0];
        doReq(1'b0, 32'h0, 32'd0, 0, rd, er);
        chk("t4-mem0", rd, prior);

        prior = refMem[0][8];
        doReq(1'b1, 32'h22, 32'hA5A50022, 0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("t6-err", 32'(er), 32'd1);
        doReq(1'b0, 32'h20, 32'd0, 0, rd, er);
        chk("t6-mem8", rd, prior);
`else
        chk("t6-err", 32'(er), 32'd0);
        doReq(1'b0, 32'h20, 32'd0, 0, rd, er);
        chk("t6-mem8", rd, 32'hA5A50022);
`endif

        doReq(1'b1, 32'h20, 32'h0BADC0DE, 0, rd, er);
        busA.ReqValid = 1'b1;
        busA.ReqWrite = 1'b1;
        busA.ReqAddr  = 32'h20;
        busA.ReqWData = 32'h12345678;
        @(posedge CLK); #1;
        busA.ReqValid = 1'b0;
        chk("t5-wait-busy", 32'(busA.ReqReady), 32'd0);
        RST_N = 1'b0;
        #1;
        checkReset("t5-reset");
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;
        doReq(1'b0, 32'h20, 32'd0, 0, rd, er);
        chk("t5-prior", rd, 32'h0BADC0DE);

        for (int i = 0; i < 40; i++)
            doReq(1'($urandom_range(0, 1)), randAddr(), $urandom,
                  $urandom_range(0, 3), rd, er);

        sel = 1; curW = 0; vif = busB;
        for (int i = 0; i < 16; i++) doReq(1'b1, 32'(i * 4), $urandom, 0, rd, er);

        busB.RspReady = 1'b1;
        busB.ReqValid = 1'b1;
        busB.ReqWrite = 1'b0;
        busB.ReqAddr  = 32'h0;
        chk("t3-ready0", 32'(busB.ReqReady), 32'd1);
        @(posedge CLK); #1;
        chk("t3-valid0", 32'(busB.RspValid), 32'd1);
        chk("t3-rdata0", busB.RspRData, refMem[1][0]);
        chk("t3-busy0", 32'(busB.ReqReady), 32'd0);
        busB.ReqAddr = 32'h4;
        @(posedge CLK); #1;
        chk("t3-gap-valid", 32'(busB.RspValid), 32'd0);
        chk("t3-gap-ready", 32'(busB.ReqReady), 32'd1);
        @(posedge CLK); #1;
        chk("t3-valid1", 32'(busB.RspValid), 32'd1);
        chk("t3-rdata1", busB.RspRData, refMem[1][1]);
        busB.ReqValid = 1'b0;
        @(posedge CLK); #1;
        chk("t3-end", 32'(busB.RspValid), 32'd0);
        busB.RspReady = 1'b0;

        for (int i = 0; i < 30; i++)
            doReq(1'($urandom_range(0, 1)), randAddr(), $urandom,
                  $urandom_range(0, 2), rd, er);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
